// File: rtl/d_cache_pkg.sv
// d_cache_pkg: shared types and constants for the 4-line direct-mapped data cache.
// Contents: geometry localparams, controller state enum, address field struct and
// the helper that builds a refill word address.
package d_cache_pkg;

  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int TAG_W          = 28;
  localparam int LINE_W         = 2;
  localparam int WORD_W         = 2;
  localparam int NUM_LINES      = 4;
  localparam int WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESP   = 2'd2,
    WRMEM  = 2'd3
  } dc_state_e;

  // Word-address split: there is no byte offset, addr[1:0] selects the word.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] line;
    logic [WORD_W-1:0] word;
  } dc_addr_t;

  // Memory address of word 'w' of the line that holds 'a'.
  function automatic logic [ADDR_W-1:0] refill_addr(input dc_addr_t a, input logic [WORD_W-1:0] w);
    return {a.tag, a.line, w};
  endfunction

endpackage

// File: rtl/d_cache_ctrl_if.sv
// Bus interfaces of the data cache controller.
// d_cache_cpu_if: core memory-stage request/response (master = core, slave = cache).
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cache ; cpu_rdata/cpu_ready -> core
// d_cache_mem_if: external memory port (master = cache, slave = memory).
//   mem_req/mem_we/mem_addr/mem_wdata -> memory ; mem_ack/mem_rdata -> cache
interface d_cache_cpu_if;
  import d_cache_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;

  modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata, input cpu_rdata, cpu_ready);
  modport slave  (input cpu_req, cpu_we, cpu_addr, cpu_wdata, output cpu_rdata, cpu_ready);
endinterface

interface d_cache_mem_if;
  import d_cache_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/d_cache_lookup.sv
// d_cache_lookup: combinational tag compare for the direct-mapped cache.
// Ports: tag_array/valid_array (array contents), req_tag/req_line (request fields),
//        hit (tag match only, valid NOT included), line_valid (valid bit of req_line).
module d_cache_lookup
  import d_cache_pkg::*;
(
  input  logic [NUM_LINES-1:0][TAG_W-1:0] tag_array,
  input  logic [NUM_LINES-1:0]            valid_array,
  input  logic [TAG_W-1:0]                req_tag,
  input  logic [LINE_W-1:0]               req_line,
  output logic                            hit,
  output logic                            line_valid
);

  assign hit        = (tag_array[req_line] == req_tag);
  assign line_valid = valid_array[req_line];

endmodule

// File: rtl/d_cache_ctrl.sv
// d_cache_ctrl: controller of the 4-line direct-mapped, write-through data cache.
// Owns tag/valid/data arrays, serves load hits in one cycle, refills a line on a
// load miss (words 0..3 in order) and forwards every store to memory (no allocate).
// Ports: clk, rst (async, active high), cpu (d_cache_cpu_if.slave),
//        mem (d_cache_mem_if.master). All bus outputs are registered.
module d_cache_ctrl
  import d_cache_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  d_cache_cpu_if.slave  cpu,
  d_cache_mem_if.master mem
);

  dc_state_e                       state_r;
  dc_addr_t                        req_s;
  dc_addr_t                        req_r;
  logic [NUM_LINES-1:0][TAG_W-1:0] tag_r;
  logic [NUM_LINES-1:0]            valid_r;
  logic [DATA_W-1:0]               data_r [NUM_LINES][WORDS_PER_LINE];
  logic [WORD_W-1:0]               cnt_r;

  logic [DATA_W-1:0]               cpu_rdata_r;
  logic                            cpu_ready_r;
  logic                            mem_req_r;
  logic                            mem_we_r;
  logic [ADDR_W-1:0]               mem_addr_r;
  logic [DATA_W-1:0]               mem_wdata_r;

  logic                            lookup_hit_s;
  logic                            line_valid_s;
  logic                            hit_s;
  logic                            accept_s;
  logic                            ack_s;

  assign req_s = cpu.cpu_addr;

  d_cache_lookup u_lookup (
    .tag_array   (tag_r),
    .valid_array (valid_r),
    .req_tag     (req_s.tag),
    .req_line    (req_s.line),
    .hit         (lookup_hit_s),
    .line_valid  (line_valid_s)
  );

  // The lookup block ignores valid, so qualify its hit here.
  assign hit_s    = lookup_hit_s & line_valid_s;
  // The cycle cpu_ready is high belongs to the finished request.
  assign accept_s = cpu.cpu_req & ~cpu_ready_r;
  // An ack without an outstanding request is ignored.
  assign ack_s    = mem.mem_ack & mem_req_r;

  assign cpu.cpu_rdata = cpu_rdata_r;
  assign cpu.cpu_ready = cpu_ready_r;
  assign mem.mem_req   = mem_req_r;
  assign mem.mem_we    = mem_we_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_wdata = mem_wdata_r;

  // Controller FSM, cache arrays and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      req_r       <= {ADDR_W{1'b0}};
      tag_r       <= {(NUM_LINES*TAG_W){1'b0}};
      valid_r     <= {NUM_LINES{1'b0}};
      cnt_r       <= 2'd0;
      cpu_rdata_r <= 32'h0;
      cpu_ready_r <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0;
      mem_wdata_r <= 32'h0;
      for (int l = 0; l < NUM_LINES; l++) begin
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
          data_r[l][w] <= 32'h0;
        end
      end
    end else begin
      cpu_ready_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            req_r <= req_s;
            if (cpu.cpu_we) begin
              // Write-through: update the line only when it is already present.
              if (hit_s) begin
                data_r[req_s.line][req_s.word] <= cpu.cpu_wdata;
              end
              mem_req_r   <= 1'b1;
              mem_we_r    <= 1'b1;
              mem_addr_r  <= cpu.cpu_addr;
              mem_wdata_r <= cpu.cpu_wdata;
              state_r     <= WRMEM;
            end else if (hit_s) begin
              cpu_rdata_r <= data_r[req_s.line][req_s.word];
              cpu_ready_r <= 1'b1;
            end else begin
              // Invalidate first so a half-filled line never looks valid.
              valid_r[req_s.line] <= 1'b0;
              cnt_r               <= 2'd0;
              mem_req_r           <= 1'b1;
              mem_we_r            <= 1'b0;
              mem_addr_r          <= refill_addr(req_s, 2'd0);
              state_r             <= REFILL;
            end
          end
        end
        REFILL: begin
          if (ack_s) begin
            data_r[req_r.line][cnt_r] <= mem.mem_rdata;
            if (cnt_r == 2'd3) begin
              tag_r[req_r.line]   <= req_r.tag;
              valid_r[req_r.line] <= 1'b1;
              mem_req_r           <= 1'b0;
              state_r             <= RESP;
            end else begin
              cnt_r      <= cnt_r + 2'd1;
              mem_addr_r <= refill_addr(req_r, cnt_r + 2'd1);
            end
          end
        end
        RESP: begin
          cpu_rdata_r <= data_r[req_r.line][req_r.word];
          cpu_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
        WRMEM: begin
          if (ack_s) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            cpu_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Self-checking bench for d_cache_ctrl: a small cache/memory model predicts memory
// operations and load data, which are queued when a request is driven and popped
// when the controller produces them.
module tb_d_cache_ctrl;

  logic clk = 1'b0;
  logic rst;

  d_cache_cpu_if cpu ();
  d_cache_mem_if mem ();

  d_cache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .cpu (cpu),
    .mem (mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_op_t;

  int          checks = 0;
  int          errors = 0;
  mem_op_t     exp_mem_q [$];
  logic [31:0] exp_rsp_q [$];
  logic        model_valid [4];
  logic [27:0] model_tag [4];
  logic [31:0] mem_model [logic [31:0]];

  // A request must stay put until the cache answers it.
  property p_req_hold;
    @(posedge clk) disable iff (rst)
      (cpu.cpu_req && !cpu.cpu_ready) |=> (cpu.cpu_ready || (cpu.cpu_req && $stable(cpu.cpu_addr)));
  endproperty
  a_req_hold: assert property (p_req_hold) else $error("protocol violation: cpu request changed before cpu_ready");

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], 16'h5A5A};
  endfunction

  // One CPU access with the bench acting as memory. delay = wait cycles before each ack;
  // abort_after > 0 asserts rst once that many acks have been consumed.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay, input int abort_after, input string name);
    logic [1:0]  line = addr[3:2];
    logic [27:0] tag  = addr[31:4];
    int          n_mem_exp = 0;
    int          n_mem_seen = 0;
    int          cyc = 0;
    int          ack_cyc = -1;
    int          acks = 0;
    int          wait_cnt = 0;
    bit          in_xfer = 1'b0;
    bit          ack_q = 1'b0;
    bit          done = 1'b0;
    bit          aborted = 1'b0;
    logic [31:0] hold = 32'h0;
    logic [31:0] exp_rd;
    mem_op_t     op;

    if (we) begin
      op.we = 1'b1; op.addr = addr; op.wdata = wdata;
      exp_mem_q.push_back(op);
      mem_model[addr] = wdata;
      n_mem_exp = 1;
    end else begin
      if (!(model_valid[line] && model_tag[line] == tag)) begin
        for (int i = 0; i < 4; i++) begin
          op.we = 1'b0; op.addr = {tag, line, 2'(i)}; op.wdata = 32'h0;
          exp_mem_q.push_back(op);
        end
        n_mem_exp = 4;
        model_valid[line] = 1'b1;
        model_tag[line]   = tag;
      end
      exp_rsp_q.push_back(memval(addr));
    end

    cpu.cpu_req = 1'b1; cpu.cpu_we = we; cpu.cpu_addr = addr; cpu.cpu_wdata = wdata;

    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ack_q) begin
        mem.mem_ack = 1'b0; ack_q = 1'b0; in_xfer = 1'b0; acks++;
      end
      if (abort_after > 0 && acks == abort_after) begin
        #2 rst = 1'b1;
        cpu.cpu_req = 1'b0;
        #1;
        checks++;
        if (mem.mem_req !== 1'b0) begin errors++; $display("FAIL %s rst_mem_req: got %b want 0", name, mem.mem_req); end
        checks++;
        if (cpu.cpu_ready !== 1'b0) begin errors++; $display("FAIL %s rst_cpu_ready: got %b want 0", name, cpu.cpu_ready); end
        checks++;
        if (dut.valid_r !== 4'b0000) begin errors++; $display("FAIL %s rst_valid: got %b want 0000", name, dut.valid_r); end
        @(negedge clk);
        rst = 1'b0;
        exp_mem_q.delete();
        exp_rsp_q.delete();
        for (int l = 0; l < 4; l++) model_valid[l] = 1'b0;
        aborted = 1'b1;
        done = 1'b1;
      end else begin
        if (cpu.cpu_ready) begin
          cpu.cpu_req = 1'b0;
          done = 1'b1;
          if (!we) begin
            exp_rd = exp_rsp_q.pop_front();
            checks++;
            if (cpu.cpu_rdata !== exp_rd) begin
              errors++; $display("FAIL %s rdata: got %h want %h", name, cpu.cpu_rdata, exp_rd);
            end
          end
          if (n_mem_exp == 0) begin
            checks++;
            if (cyc != 1) begin errors++; $display("FAIL %s hit_latency: got %0d want 1", name, cyc); end
          end else begin
            checks++;
            if (cyc - ack_cyc != (we ? 1 : 2)) begin
              errors++; $display("FAIL %s ack_to_ready: got %0d want %0d", name, cyc - ack_cyc, (we ? 1 : 2));
            end
          end
        end
        if (mem.mem_req) begin
          if (!in_xfer) begin
            in_xfer = 1'b1; wait_cnt = 0; hold = mem.mem_addr; n_mem_seen++;
            checks++;
            if (exp_mem_q.size() == 0) begin
              errors++; $display("FAIL %s unexpected_mem_req: got addr %h want none", name, mem.mem_addr);
            end else begin
              op = exp_mem_q.pop_front();
              if (mem.mem_we !== op.we || mem.mem_addr !== op.addr || (op.we && mem.mem_wdata !== op.wdata)) begin
                errors++;
                $display("FAIL %s mem_op: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                         name, mem.mem_we, mem.mem_addr, mem.mem_wdata, op.we, op.addr, op.wdata);
              end
            end
          end else begin
            checks++;
            if (mem.mem_addr !== hold) begin
              errors++; $display("FAIL %s mem_addr_stable: got %h want %h", name, mem.mem_addr, hold);
            end
          end
          if (wait_cnt >= delay) begin
            mem.mem_rdata = mem.mem_we ? 32'h0 : memval(mem.mem_addr);
            mem.mem_ack = 1'b1; ack_q = 1'b1; ack_cyc = cyc;
          end else begin
            wait_cnt++;
          end
        end
      end
    end

    checks++;
    if (!done) begin
      errors++; $display("FAIL %s timeout: got no cpu_ready want cpu_ready within 200 cycles", name);
      cpu.cpu_req = 1'b0; mem.mem_ack = 1'b0;
    end else if (!aborted) begin
      @(negedge clk);
      checks++;
      if (cpu.cpu_ready !== 1'b0) begin errors++; $display("FAIL %s ready_pulse: got %b want 0", name, cpu.cpu_ready); end
      checks++;
      if (mem.mem_req !== 1'b0 || n_mem_seen != n_mem_exp) begin
        errors++; $display("FAIL %s mem_count: got %0d req=%b want %0d req=0", name, n_mem_seen, mem.mem_req, n_mem_exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu.cpu_req = 1'b0; cpu.cpu_we = 1'b0; cpu.cpu_addr = 32'h0; cpu.cpu_wdata = 32'h0;
    mem.mem_ack = 1'b0; mem.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cpu.cpu_ready, mem.mem_req, mem.mem_we} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got ready/req/we=%b want 000", {cpu.cpu_ready, mem.mem_req, mem.mem_we});
    end
    checks++;
    if (cpu.cpu_rdata !== 32'h0 || mem.mem_addr !== 32'h0 || mem.mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want zeros", cpu.cpu_rdata, mem.mem_addr, mem.mem_wdata);
    end
    checks++;
    if (dut.valid_r !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b want 0000", dut.valid_r); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cold_load();
    access(1'b0, 32'h10, 32'h0, 0, 0, "cold_load");
    checks++;
    if (dut.valid_r[0] !== 1'b1) begin errors++; $display("FAIL cold_load_valid0: got %b want 1", dut.valid_r[0]); end
  endtask

  task automatic test_load_hit();
    access(1'b0, 32'h12, 32'h0, 0, 0, "load_hit");
  endtask

  task automatic test_store_hit();
    access(1'b1, 32'h11, 32'hDEADBEEF, 0, 0, "store_hit");
    access(1'b0, 32'h11, 32'h0, 0, 0, "load_after_store");
  endtask

  task automatic test_store_miss();
    access(1'b1, 32'h20, 32'h12345678, 0, 0, "store_miss");
    checks++;
    if (dut.valid_r[0] !== 1'b1 || dut.tag_r[0] !== 28'h1) begin
      errors++; $display("FAIL store_miss_no_alloc: got valid=%b tag=%h want 1 and 0000001", dut.valid_r[0], dut.tag_r[0]);
    end
    access(1'b0, 32'h20, 32'h0, 0, 0, "load_evict");
    checks++;
    if (dut.tag_r[0] !== 28'h2) begin errors++; $display("FAIL evict_tag: got %h want 0000002", dut.tag_r[0]); end
    access(1'b0, 32'h10, 32'h0, 0, 0, "reload_evicted");
  endtask

  task automatic test_reset_mid_refill();
    access(1'b0, 32'h20, 32'h0, 0, 2, "reset_mid_refill");
    access(1'b0, 32'h10, 32'h0, 0, 0, "refill_after_reset");
  endtask

  task automatic test_delayed_ack();
    access(1'b0, 32'h34, 32'h0, 5, 0, "slow_refill");
    access(1'b1, 32'h35, 32'hCAFEF00D, 3, 0, "slow_store");
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h34, 32'h36, 32'h35};
    logic [31:0] exp_rd;
    for (int i = 0; i < 3; i++) exp_rsp_q.push_back(memval(addrs[i]));
    cpu.cpu_we = 1'b0; cpu.cpu_addr = addrs[0]; cpu.cpu_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_rd = exp_rsp_q.pop_front();
      checks++;
      if (cpu.cpu_ready !== 1'b1 || cpu.cpu_rdata !== exp_rd || mem.mem_req !== 1'b0) begin
        errors++; $display("FAIL b2b_hit%0d: got ready=%b rdata=%h req=%b want 1 %h 0", i, cpu.cpu_ready, cpu.cpu_rdata, mem.mem_req, exp_rd);
      end
      if (i < 2) cpu.cpu_addr = addrs[i+1];
      else cpu.cpu_req = 1'b0;
      @(negedge clk);
      checks++;
      if (cpu.cpu_ready !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d: got ready=%b want 0", i, cpu.cpu_ready); end
    end
  endtask

  initial begin
    for (int l = 0; l < 4; l++) begin model_valid[l] = 1'b0; model_tag[l] = 28'h0; end
    for (int i = 0; i < 4; i++) mem_model[32'h10 + i] = 32'hA0A0_0000 + i;
    test_reset();
    test_cold_load();
    test_load_hit();
    test_store_hit();
    test_store_miss();
    test_reset_mid_refill();
    test_delayed_ack();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
